// File: rtl/damage_arbiter.sv
// -----------------------------------------------------------------------------
// damage_arbiter
//
// Shares a tower's single damage port (damageIn / attackSCEN) among N_REQ
// attacking units. At most one attack event is issued per rising edge of the
// game tick. The granted unit's damage is latched onto damageOut and a
// one-clk strobe is pulsed to the tower. Arbitration stops (HALT) once the
// tower reports dead, and resumes only after the level is restarted through
// enable.
//
// Build option:
//   DAMAGE_COMBINE_EN  defined   -> every requester is granted on a tick;
//                                   damageOut is the saturating sum of their
//                                   damages, with a single strobe.
//                      undefined -> a single round-robin grant per tick.
//
// Parameters:
//   N_REQ  number of requesting units (2..8)
//   DMG_W  damage width, matches the tower's damageIn
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   gameClk      game tick level, synchronous to clk (rising edge = tick)
//   enable       level in progress; low forces IDLE
//   towerDead    target tower's dead flag
//   req          per-unit attack request, held until granted
//   reqDamage    unit i's damage in bits [i*DMG_W +: DMG_W]
//   grant        one-clk grant pulse per unit
//   damageOut    damage for the tower, valid while attackSCEN is high
//   attackSCEN   one-clk attack strobe to the tower
//   halted       high while in HALT
//   attackCount  attack events this level, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module damage_arbiter #(
  parameter int N_REQ = 4,
  parameter int DMG_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   gameClk,
  input  logic                   enable,
  input  logic                   towerDead,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*DMG_W-1:0] reqDamage,
  output logic [N_REQ-1:0]       grant,
  output logic [DMG_W-1:0]       damageOut,
  output logic                   attackSCEN,
  output logic                   halted,
  output logic [15:0]            attackCount
);

  localparam int PTR_W = $clog2(N_REQ);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  // Pointer value that makes unit 0 the first winner of a level.
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

  logic [1:0]       state_q,   state_d;
  logic             gameclk_q;
  logic [PTR_W-1:0] ptr_q,     ptr_d;
  logic [N_REQ-1:0] grant_q,   grant_d;
  logic             attack_q,  attack_d;
  logic [DMG_W-1:0] damage_q,  damage_d;
  logic             halted_q,  halted_d;
  logic [15:0]      count_q,   count_d;

  logic tick;

  assign tick = gameClk & ~gameclk_q;

`ifdef DAMAGE_COMBINE_EN
  // Wide enough to hold the sum of all N_REQ damages without overflow.
  localparam int SUM_W = DMG_W + PTR_W + 1;

  logic [SUM_W-1:0] comb_sum;
  logic [DMG_W-1:0] comb_dmg;

  always_comb begin
    comb_sum = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i]) begin
        comb_sum = comb_sum + SUM_W'(reqDamage[i*DMG_W +: DMG_W]);
      end
    end
    if (comb_sum > SUM_W'({DMG_W{1'b1}})) begin
      comb_dmg = {DMG_W{1'b1}};
    end else begin
      comb_dmg = comb_sum[DMG_W-1:0];
    end
  end
`else
  // Round-robin search starting just after the last winner.
  logic [PTR_W-1:0] rr_idx;
  logic [PTR_W-1:0] rr_cand;
  logic             rr_found;

  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    rr_cand  = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      rr_cand = PTR_W'((int'(ptr_q) + off) % N_REQ);
      if (!rr_found && req[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves it unassigned; an unassigned path would infer a latch.
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = '0;
    attack_d = 1'b0;
    damage_d = damage_q;
    count_d  = count_q;

    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Start of a level: fresh count, unit 0 wins first.
          count_d = '0;
          ptr_d   = PTR_LAST;
          state_d = towerDead ? ST_HALT : ST_WAIT;
        end
        ST_WAIT: begin
          if (towerDead) begin
            state_d = ST_HALT;
          end else if (tick && (|req)) begin
`ifdef DAMAGE_COMBINE_EN
            grant_d  = req;
            damage_d = comb_dmg;
`else
            grant_d[rr_idx] = 1'b1;
            damage_d        = reqDamage[int'(rr_idx)*DMG_W +: DMG_W];
            ptr_d           = rr_idx;
`endif
            attack_d = 1'b1;
            count_d  = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
          end
        end
        ST_HALT: begin
          state_d = ST_HALT;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    halted_d = (state_d == ST_HALT);
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gameclk_q <= 1'b0;
      ptr_q     <= PTR_LAST;
      grant_q   <= '0;
      attack_q  <= 1'b0;
      damage_q  <= '0;
      halted_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      gameclk_q <= gameClk;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      attack_q  <= attack_d;
      damage_q  <= damage_d;
      halted_q  <= halted_d;
      count_q   <= count_d;
    end
  end

  assign grant       = grant_q;
  assign attackSCEN  = attack_q;
  assign damageOut   = damage_q;
  assign halted      = halted_q;
  assign attackCount = count_q;

endmodule
